// File: rtl/cpu_controller_mc_if.sv
// Memory request/ready handshake between the multicycle controller (master) and memory (slave).
interface cpu_controller_mc_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/cpu_controller_mc.sv
// Multicycle fetch/decode/execute controller for the RISC CPU with a req/ready memory handshake.
// Define CTRL_PERF_CNT_EN to add the saturating retired-instruction counter port.
module cpu_controller_mc #(
  parameter int REGSEL_W     = 2,
  parameter int WBSEL_W      = 2,
  parameter int MEM_WAIT_MAX = 15,
  parameter int PERF_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          opcode,
  input  logic [1:0]          op,
  input  logic                Z,
  input  logic                N,
  input  logic                V,
  cpu_controller_mc_if.master mem,
  output logic [REGSEL_W-1:0] reg_sel,
  output logic [WBSEL_W-1:0]  wb_sel,
  output logic                w_en,
  output logic                en_A,
  output logic                en_B,
  output logic                en_C,
  output logic                en_status,
  output logic                sel_A,
  output logic                sel_B,
  output logic                load_pc,
  output logic                sel_pc,
  output logic                clear_pc,
  output logic                load_ir,
  output logic                load_addr,
  output logic                sel_addr,
  output logic                halted,
  output logic                mem_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]   retired
`endif
);

  typedef enum logic [4:0] {
    RESET, F_REQ, F_WAIT, PC_INC, DECODE, MOV_IMM, GET_A, GET_B, EXEC, STATUS,
    WB, ADDR, M_ADDR, S_GETB, S_PASS, M_WAIT, M_DONE, LDR_WB, BRANCH, HALT
  } state_t;

  localparam logic [REGSEL_W-1:0] REG_RD = REGSEL_W'(0);
  localparam logic [REGSEL_W-1:0] REG_RM = REGSEL_W'(1);
  localparam logic [REGSEL_W-1:0] REG_RN = REGSEL_W'(2);
  localparam logic [WBSEL_W-1:0]  WB_C   = WBSEL_W'(0);
  localparam logic [WBSEL_W-1:0]  WB_MEM = WBSEL_W'(1);
  localparam logic [WBSEL_W-1:0]  WB_IMM = WBSEL_W'(2);

  localparam int WD_W   = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam int WD_LIM = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LIM[WD_W-1:0];

  state_t          state, next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            wait_state, wd_fire;
  logic            is_cmp, is_mov, is_str, is_mem, taken;

  assign is_cmp = (opcode == 3'b101) && (op == 2'b01);
  assign is_mov = ((opcode == 3'b110) && (op == 2'b00)) || ((opcode == 3'b101) && (op == 2'b11));
  assign is_str = (opcode == 3'b100);
  assign is_mem = (opcode == 3'b011) || (opcode == 3'b100);

  always_comb begin
    unique case (op)
      2'b00:   taken = 1'b1;
      2'b01:   taken = Z;
      2'b10:   taken = ~Z;
      default: taken = N ^ V;
    endcase
  end

  // The watchdog fires on the MEM_WAIT_MAX-th consecutive not-ready cycle of a wait state.
  assign wait_state = (state == F_WAIT) || (state == M_WAIT);
  assign wd_fire    = (MEM_WAIT_MAX != 0) && wait_state && !mem.mem_ready && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET;
      wd_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= next_state;
      if (wait_state && !mem.mem_ready) wd_cnt <= wd_cnt + 1'b1;
      else                              wd_cnt <= '0;
      if (wd_fire) mem_err <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    reg_sel      = '1;
    wb_sel       = WB_C;
    w_en         = 1'b0;
    en_A         = 1'b0;
    en_B         = 1'b0;
    en_C         = 1'b0;
    en_status    = 1'b0;
    sel_A        = 1'b0;
    sel_B        = 1'b0;
    load_pc      = 1'b0;
    sel_pc       = 1'b0;
    clear_pc     = 1'b0;
    load_ir      = 1'b0;
    load_addr    = 1'b0;
    sel_addr     = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    halted       = 1'b0;
    unique case (state)
      RESET:   begin clear_pc = 1'b1; next_state = F_REQ; end
      F_REQ:   begin load_addr = 1'b1; next_state = F_WAIT; end
      F_WAIT: begin
        mem.mem_req = 1'b1;
        load_ir     = mem.mem_ready;
        if (mem.mem_ready) next_state = PC_INC;
        else if (wd_fire)  next_state = HALT;
      end
      PC_INC:  begin load_pc = 1'b1; next_state = DECODE; end
      DECODE: begin
        unique casez ({opcode, op})
          5'b110_10:                                 next_state = MOV_IMM;
          5'b110_00, 5'b101_11:                      next_state = GET_B;
          5'b101_00, 5'b101_01, 5'b101_10,
          5'b011_00, 5'b100_00:                      next_state = GET_A;
          5'b001_??:                                 next_state = BRANCH;
          5'b111_??:                                 next_state = HALT;
          default:                                   next_state = F_REQ;
        endcase
      end
      MOV_IMM: begin w_en = 1'b1; reg_sel = REG_RN; wb_sel = WB_IMM; next_state = F_REQ; end
      GET_A:   begin reg_sel = REG_RN; en_A = 1'b1; next_state = is_mem ? ADDR : GET_B; end
      GET_B:   begin reg_sel = REG_RM; en_B = 1'b1; next_state = is_cmp ? STATUS : EXEC; end
      EXEC:    begin en_C = 1'b1; sel_A = is_mov; next_state = WB; end
      STATUS:  begin en_status = 1'b1; next_state = F_REQ; end
      WB:      begin w_en = 1'b1; reg_sel = REG_RD; wb_sel = WB_C; next_state = F_REQ; end
      ADDR:    begin sel_B = 1'b1; en_C = 1'b1; next_state = M_ADDR; end
      M_ADDR:  begin load_addr = 1'b1; sel_addr = 1'b1; next_state = is_str ? S_GETB : M_WAIT; end
      S_GETB:  begin reg_sel = REG_RD; en_B = 1'b1; next_state = S_PASS; end
      S_PASS:  begin sel_A = 1'b1; en_C = 1'b1; next_state = M_WAIT; end
      M_WAIT: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = is_str;
        if (mem.mem_ready) next_state = M_DONE;
        else if (wd_fire)  next_state = HALT;
      end
      // Spare cycle after the data transfer lets read data settle before write-back.
      M_DONE:  next_state = is_str ? F_REQ : LDR_WB;
      LDR_WB:  begin w_en = 1'b1; reg_sel = REG_RD; wb_sel = WB_MEM; next_state = F_REQ; end
      BRANCH: begin
        load_pc    = taken;
        sel_pc     = taken;
        next_state = F_REQ;
      end
      HALT:    halted = 1'b1;
      default: next_state = RESET;
    endcase
    // While rst is held every output is quiet, so an in-flight request drops at once.
    if (rst) begin
      reg_sel     = '1;
      wb_sel      = WB_C;
      w_en        = 1'b0;
      en_A        = 1'b0;
      en_B        = 1'b0;
      en_C        = 1'b0;
      en_status   = 1'b0;
      sel_A       = 1'b0;
      sel_B       = 1'b0;
      load_pc     = 1'b0;
      sel_pc      = 1'b0;
      clear_pc    = 1'b0;
      load_ir     = 1'b0;
      load_addr   = 1'b0;
      sel_addr    = 1'b0;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire;

  assign retire = (next_state == F_REQ) &&
                  (state inside {MOV_IMM, WB, STATUS, LDR_WB, M_DONE, BRANCH, DECODE});

  always_ff @(posedge clk) begin
    if (rst)                          retired <= '0;
    else if (retire && retired != '1) retired <= retired + 1'b1;
  end
`endif

endmodule
